// File: rtl/boot_loader_if.sv
// Byte-stream and instruction-memory bundle for the boot loader.
// The loader is the slave of the byte stream and drives the memory write port.
interface boot_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_w_enb;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, mem_w_enb, mem_addr, mem_w_data
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, mem_w_enb, mem_addr, mem_w_data
    );
endinterface

// File: rtl/boot_loader.sv
// Loads a length-prefixed little-endian word image into instruction memory.
// Define BOOT_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module boot_loader #(
    parameter int ADDR_BITS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    boot_loader_if.slave bus,
    output logic         core_rst,
    output logic         busy,
    output logic         done,
    output logic [1:0]   err_code
);
    localparam int          MAX_WORDS = 2 ** (ADDR_BITS - 2);
    localparam logic [16:0] MAX_W     = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, DATA, WRITE, CHK, DONE, ERR
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [23:0] word_q, word_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  err_q, err_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        rdy;
    logic        xfer;
    logic [15:0] n_rx;
    logic [15:0] idx_inc;

    assign rdy = (state_q == LEN0) || (state_q == LEN1) ||
                 (state_q == DATA) || (state_q == CHK);
    assign xfer    = bus.rx_valid && rdy;
    assign n_rx    = {bus.rx_data, len_q[7:0]};
    assign idx_inc = idx_q + 16'd1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
`ifdef BOOT_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN0;
                    err_d   = 2'b00;
                    idx_d   = '0;
                    bcnt_d  = '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            LEN0: begin
                if (xfer) begin
                    len_d[7:0] = bus.rx_data;
                    state_d    = LEN1;
                end
            end
            LEN1: begin
                if (xfer) begin
                    len_d[15:8] = bus.rx_data;
                    if (n_rx != 16'd0 && {1'b0, n_rx} <= MAX_W) begin
                        state_d = DATA;
                    end else begin
                        state_d = ERR;
                        err_d   = 2'b01;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    bcnt_d = bcnt_q + 2'd1;
`ifdef BOOT_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ bus.rx_data;
`endif
                    unique case (bcnt_q)
                        2'd0: word_d[7:0]   = bus.rx_data;
                        2'd1: word_d[15:8]  = bus.rx_data;
                        2'd2: word_d[23:16] = bus.rx_data;
                        default: begin
                            // Address and data are latched here so the
                            // memory port is purely registered in WRITE.
                            state_d = WRITE;
                            addr_d  = 32'({idx_q[ADDR_BITS-3:0], 2'b00});
                            wdata_d = {bus.rx_data, word_q};
                        end
                    endcase
                end
            end
            WRITE: begin
                idx_d = idx_inc;
                if (idx_inc == len_q) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                    state_d = CHK;
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = DATA;
                end
            end
            CHK: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                if (xfer) begin
                    if (bus.rx_data == csum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERR;
                        err_d   = 2'b10;
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
`ifdef BOOT_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign bus.rx_ready   = rdy;
    assign bus.mem_w_enb  = (state_q == WRITE);
    assign bus.mem_addr   = addr_q;
    assign bus.mem_w_data = wdata_q;
    assign busy     = rdy || (state_q == WRITE);
    assign done     = (state_q == DONE);
    assign core_rst = (state_q != DONE);
    assign err_code = err_q;
endmodule

// File: tb/tb_boot_loader.sv
// Randomised boot_loader bench: a stream model fills a write scoreboard,
// a negedge monitor checks every memory write against it.
module tb_boot_loader;
    localparam int AB   = 10;
    localparam int MAXW = 2 ** (AB - 2);

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       core_rst;
    logic       busy;
    logic       done;
    logic [1:0] err_code;

    boot_loader_if bus();

    boot_loader #(.ADDR_BITS(AB)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus),
        .core_rst(core_rst),
        .busy    (busy),
        .done    (done),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    wr_t exp_q[$];
    wr_t mon_e;
    int  vectors     = 0;
    int  miscompares = 0;
    bit  want_lat    = 1'b0;
    bit  lat_arm     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (lat_arm) begin
            chk("done_latency", {30'd0, done, core_rst}, 32'd2);
            lat_arm = 1'b0;
        end
        if (bus.mem_w_enb) begin
            chk("ready_in_write", {31'd0, bus.rx_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr %h data %h, none expected",
                         bus.mem_addr, bus.mem_w_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", bus.mem_addr, mon_e.a);
                chk("wr_data", bus.mem_w_data, mon_e.d);
                if (exp_q.size() == 0 && want_lat) lat_arm = 1'b1;
            end
        end
    end

    // Reference: decode the stream by its format rules, queue the words
    // whose four bytes were all delivered, and predict the final outcome.
    task automatic model(input bq_t s, input int nsent, output bit ok,
                         output logic [1:0] err, output int nsend);
        int n;
`ifdef BOOT_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
`endif
        n = int'({s[1], s[0]});
        if (n == 0 || n > MAXW) begin
            ok    = 1'b0;
            err   = 2'b01;
            nsend = 2;
            return;
        end
        for (int i = 0; i < n; i++) begin
            wr_t w;
            w.a = 32'(4 * i);
            w.d = {s[5+4*i], s[4+4*i], s[3+4*i], s[2+4*i]};
            if (6 + 4 * i <= nsent) exp_q.push_back(w);
`ifdef BOOT_LOADER_CHECKSUM_EN
            x = x ^ s[2+4*i] ^ s[3+4*i] ^ s[4+4*i] ^ s[5+4*i];
`endif
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        ok    = (s[2+4*n] == x);
        err   = ok ? 2'b00 : 2'b10;
        nsend = 4 * n + 3;
`else
        ok    = 1'b1;
        err   = 2'b00;
        nsend = 4 * n + 2;
`endif
    endtask

    function automatic bq_t img(input logic [31:0] w[$]);
        bq_t         s;
        logic [15:0] n;
        n = 16'(w.size());
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
        foreach (w[i])
            for (int k = 0; k < 4; k++) s.push_back(w[i][8*k +: 8]);
        return s;
    endfunction

    function automatic bq_t fin(input bq_t s);
`ifdef BOOT_LOADER_CHECKSUM_EN
        logic [7:0] x;
        bq_t        r;
        x = 8'h00;
        r = s;
        for (int i = 2; i < s.size(); i++) x = x ^ s[i];
        r.push_back(x);
        return r;
`else
        return s;
`endif
    endfunction

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                bus.rx_data = 8'($urandom);
            end
        end
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (!bus.rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_ready_timeout: rx_ready %b after 20 cycles, expected 1",
                     bus.rx_ready);
            $display("== %0d vectors applied, %0d miscompares ==",
                     vectors, miscompares);
            $fatal(1, "stream stalled");
        end
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start(input bit check);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (check) begin
            chk("start_busy", {31'd0, busy}, 32'd1);
            chk("start_done", {31'd0, done}, 32'd0);
            chk("start_core_rst", {31'd0, core_rst}, 32'd1);
        end
    endtask

    task automatic run_load(input bq_t s, input int mid_start);
        bit         ok;
        logic [1:0] e;
        int         ns;
        int         t;
        model(s, s.size(), ok, e, ns);
`ifdef BOOT_LOADER_CHECKSUM_EN
        want_lat = 1'b0;
`else
        want_lat = ok;
`endif
        pulse_start(1'b1);
        for (int i = 0; i < ns; i++) begin
            if (i == mid_start) pulse_start(1'b0);
            send_byte(s[i]);
        end
        t = 0;
        while (!done && err_code == 2'b00 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("done", {31'd0, done}, {31'd0, ok});
        chk("err_code", {30'd0, err_code}, {30'd0, e});
        chk("core_rst", {31'd0, core_rst}, {31'd0, !ok});
        chk("busy_end", {31'd0, busy}, 32'd0);
        chk("ready_end", {31'd0, bus.rx_ready}, 32'd0);
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] w[$];
        bq_t         s;
        bit          ok;
        logic [1:0]  e;
        int          ns;

        rst          = 1'b0;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #1 rst = 1'b1;
        #2;
        chk("rst_ready", {31'd0, bus.rx_ready}, 32'd0);
        chk("rst_wenb", {31'd0, bus.mem_w_enb}, 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_w_data, 32'd0);
        chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {30'd0, err_code}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Stray bytes while idle must not be consumed.
        repeat (4) begin
            @(negedge clk);
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'($urandom);
            chk("idle_ready", {31'd0, bus.rx_ready}, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;

        w.delete();
        w.push_back(32'h0000_0013);
        run_load(fin(img(w)), -1);

        w.delete();
        w.push_back(32'h1122_3344);
        w.push_back(32'h5566_7788);
        w.push_back(32'h99AA_BBCC);
        run_load(fin(img(w)), -1);

        w.delete();
        repeat (4) w.push_back($urandom);
        run_load(fin(img(w)), 7);

        s.delete();
        s.push_back(8'h00);
        s.push_back(8'h00);
        run_load(s, -1);
        s.delete();
        s.push_back(8'h01);
        s.push_back(8'h01);
        run_load(s, -1);

        repeat (6) begin
            w.delete();
            repeat ($urandom_range(1, 8)) w.push_back($urandom);
            s = fin(img(w));
`ifdef BOOT_LOADER_CHECKSUM_EN
            if ($urandom_range(0, 1) == 1) s[s.size()-1] = s[s.size()-1] ^ 8'h5A;
`endif
            run_load(s, -1);
        end

        w.delete();
        repeat (MAXW) w.push_back($urandom);
        run_load(fin(img(w)), -1);

`ifdef BOOT_LOADER_CHECKSUM_EN
        w.delete();
        w.push_back(32'h0403_0201);
        s = img(w);
        s.push_back(8'h04);
        run_load(s, -1);
        s[s.size()-1] = 8'h05;
        run_load(s, -1);
`endif

        // Abort after five payload bytes of a two-word image.
        w.delete();
        w.push_back($urandom);
        w.push_back($urandom);
        s = fin(img(w));
        model(s, 7, ok, e, ns);
        want_lat = 1'b0;
        pulse_start(1'b1);
        for (int i = 0; i < 7; i++) send_byte(s[i]);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_core_rst", {31'd0, core_rst}, 32'd1);
        chk("abort_ready", {31'd0, bus.rx_ready}, 32'd0);
        chk("abort_addr", bus.mem_addr, 32'd0);
        chk("abort_wdata", bus.mem_w_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_pending", 32'(exp_q.size()), 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        exp_q.delete();

        w.delete();
        repeat (3) w.push_back($urandom);
        run_load(fin(img(w)), -1);

        repeat (3) @(negedge clk);
        finish_run();
    end
endmodule
